// File: rtl/baw_pkg.sv
// Shared constants and the press-pulse priority picker for the black-and-white
// card game front end.
package baw_pkg;

    localparam int unsigned BTN_CENTER = 0;
    localparam int unsigned BTN_TOP    = 1;
    localparam int unsigned BTN_BOTTOM = 2;
    localparam int unsigned BTN_LEFT   = 3;
    localparam int unsigned BTN_RIGHT  = 4;
    localparam int unsigned NUM_BTN    = 5;

    localparam int unsigned SW_W = 16;

    // 10 ms at 100 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    // Keep only the lowest-index request: Center beats Top beats ... Right.
    function automatic logic [NUM_BTN-1:0] prio_pick(input logic [NUM_BTN-1:0] req);
        logic found;
        prio_pick = '0;
        found     = 1'b0;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            if (req[i] && !found) begin
                prio_pick[i] = 1'b1;
                found        = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: two-flop synchroniser, stability counter, accepted level and a
// combinational rise strobe that is high on the cycle the level is about to go 0->1.
module debounce_channel
    import baw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic level_o,
    output logic rise_c_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             synced;

    assign synced  = sync_q[1];
    assign level_o = stable_q;

    // Any cycle that agrees with the accepted level restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        rise_c_o = 1'b0;
        if (synced != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = synced;
                rise_c_o = synced;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/baw_input_conditioner.sv
// Board-pin conditioning: five debounced buttons with arbitrated one-shot press
// pulses, plus two-flop synchronised slide switches.
module baw_input_conditioner
    import baw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               btnCenter,
    input  logic               btnTop,
    input  logic               btnBottom,
    input  logic               btnLeft,
    input  logic               btnRight,
    input  logic [SW_W-1:0]    sw,
    output logic [SW_W-1:0]    sw_sync,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic               btn_any
);

    logic [NUM_BTN-1:0] raw_btn;
    logic [NUM_BTN-1:0] rise_c;
    logic [NUM_BTN-1:0] pulse_d, pulse_q;
    logic               any_d, any_q;
    logic [SW_W-1:0]    sw_meta_q, sw_sync_q;

    assign raw_btn = {btnRight, btnLeft, btnBottom, btnTop, btnCenter};

    for (genvar g = 0; g < int'(NUM_BTN); g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw_i    (raw_btn[g]),
            .level_o  (btn_level[g]),
            .rise_c_o (rise_c[g])
        );
    end

    // Simultaneous presses: the winner is kept, the rest are dropped for good.
    always_comb begin
        pulse_d = prio_pick(rise_c);
        any_d   = |pulse_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            pulse_q   <= '0;
            any_q     <= 1'b0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            pulse_q   <= pulse_d;
            any_q     <= any_d;
        end
    end

    assign sw_sync   = sw_sync_q;
    assign btn_pulse = pulse_q;
    assign btn_any   = any_q;

endmodule

// File: tb/tb_baw_input_conditioner.sv
// Bench for baw_input_conditioner: step table for button patterns, a pulse
// scoreboard checked every cycle, and hand sequences for latency and reset corners.
module tb_baw_input_conditioner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        b_c = 1'b0, b_t = 1'b0, b_b = 1'b0, b_l = 1'b0, b_r = 1'b0;
    logic [15:0] sw = '0;
    logic [15:0] sw_sync, d1_sw_sync;
    logic [4:0]  btn_level, btn_pulse, d1_level, d1_pulse;
    logic        btn_any, d1_any;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [4:0] btn;
        int         cycles;
        logic [4:0] push;
        logic       chk;
        logic [4:0] level;
    } step_t;

    typedef struct {
        int         edge_no;
        logic [4:0] pulse;
    } exp_t;

    step_t       tab[15];
    exp_t        sbq[$];
    logic [15:0] sw_tab[4];

    baw_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset_n(rst_n),
        .btnCenter(b_c), .btnTop(b_t), .btnBottom(b_b), .btnLeft(b_l), .btnRight(b_r),
        .sw(sw), .sw_sync(sw_sync), .btn_level(btn_level),
        .btn_pulse(btn_pulse), .btn_any(btn_any)
    );

    baw_input_conditioner #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(rst_n),
        .btnCenter(b_c), .btnTop(b_t), .btnBottom(b_b), .btnLeft(b_l), .btnRight(b_r),
        .sw(sw), .sw_sync(d1_sw_sync), .btn_level(d1_level),
        .btn_pulse(d1_pulse), .btn_any(d1_any)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_btn(input logic [4:0] v);
        b_c = v[0]; b_t = v[1]; b_b = v[2]; b_l = v[3]; b_r = v[4];
    endtask

    // Every cycle the pulse must equal the scoreboard entry due now, else zero.
    always @(negedge clk) begin
        logic [4:0] exp_p;
        exp_p = '0;
        if (sbq.size() > 0 && sbq[0].edge_no == cyc) begin
            exp_p = sbq[0].pulse;
            void'(sbq.pop_front());
        end
        chk("btn_pulse", 32'(btn_pulse), 32'(exp_p));
        chk("btn_any", 32'(btn_any), 32'(|exp_p));
    end

    initial begin
        tab[0]  = '{5'b00010, 12, 5'b00010, 1'b1, 5'b00010};
        tab[1]  = '{5'b00000, 10, 5'b00000, 1'b1, 5'b00000};
        tab[2]  = '{5'b10101, 12, 5'b00001, 1'b1, 5'b10101};
        tab[3]  = '{5'b00000, 10, 5'b00000, 1'b1, 5'b00000};
        tab[4]  = '{5'b11000, 12, 5'b01000, 1'b1, 5'b11000};
        tab[5]  = '{5'b00000, 10, 5'b00000, 1'b1, 5'b00000};
        tab[6]  = '{5'b00001, 10, 5'b00001, 1'b1, 5'b00001};
        tab[7]  = '{5'b00011, 12, 5'b00010, 1'b1, 5'b00011};
        tab[8]  = '{5'b00000, 10, 5'b00000, 1'b1, 5'b00000};
        tab[9]  = '{5'b01000, 3,  5'b00000, 1'b0, 5'b00000};
        tab[10] = '{5'b00000, 1,  5'b00000, 1'b0, 5'b00000};
        tab[11] = '{5'b01000, 2,  5'b00000, 1'b0, 5'b00000};
        tab[12] = '{5'b00000, 1,  5'b00000, 1'b0, 5'b00000};
        tab[13] = '{5'b01000, 12, 5'b01000, 1'b1, 5'b01000};
        tab[14] = '{5'b00000, 10, 5'b00000, 1'b1, 5'b00000};
        sw_tab[0] = 16'hA5C3;
        sw_tab[1] = 16'h0000;
        sw_tab[2] = 16'hFFFF;
        sw_tab[3] = 16'h5A3C;

        // Reset with every input active: nothing may leak through.
        #1 rst_n = 1'b0;
        sw = 16'hFFFF;
        set_btn(5'b11111);
        repeat (3) begin
            @(negedge clk);
            chk("rst_sw_sync", 32'(sw_sync), 32'h0);
            chk("rst_btn_level", 32'(btn_level), 32'h0);
        end
        sw = '0;
        set_btn(5'b00000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            set_btn(tab[i].btn);
            if (tab[i].push != 5'b00000) sbq.push_back('{cyc + 6, tab[i].push});
            repeat (tab[i].cycles) @(negedge clk);
            if (tab[i].chk) chk($sformatf("level_row%0d", i), 32'(btn_level), 32'(tab[i].level));
        end

        // Exact press latency, and the one-cycle-debounce instance.
        set_btn(5'b00010);
        sbq.push_back('{cyc + 6, 5'b00010});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 2) chk("d1_pulse_early", 32'(d1_pulse), 32'h0);
            if (k == 3) chk("d1_pulse", 32'(d1_pulse), 32'h02);
            if (k == 4) chk("d1_pulse_once", 32'(d1_pulse), 32'h0);
            if (k == 5) chk("press_level_k5", 32'(btn_level[1]), 32'h0);
            if (k == 6) chk("press_level_k6", 32'(btn_level[1]), 32'h1);
        end
        // Exact release latency; the monitor enforces no pulse.
        set_btn(5'b00000);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 5) chk("release_level_k5", 32'(btn_level[1]), 32'h1);
            if (k == 6) chk("release_level_k6", 32'(btn_level[1]), 32'h0);
        end

        for (int i = 0; i < 4; i++) begin
            logic [15:0] prev;
            prev = (i == 0) ? 16'h0000 : sw_tab[i-1];
            sw = sw_tab[i];
            @(negedge clk);
            chk("sw_sync_k", 32'(sw_sync), 32'(prev));
            @(negedge clk);
            chk("sw_sync_k1", 32'(sw_sync), 32'(sw_tab[i]));
            repeat (3) @(negedge clk);
            chk("sw_sync_hold", 32'(sw_sync), 32'(sw_tab[i]));
        end

        // Reset while Left is stable and Right is mid-count.
        set_btn(5'b01000);
        sbq.push_back('{cyc + 6, 5'b01000});
        repeat (10) @(negedge clk);
        chk("left_level", 32'(btn_level), 32'h08);
        set_btn(5'b11000);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_level", 32'(btn_level), 32'h0);
        chk("async_sw_sync", 32'(sw_sync), 32'h0);
        chk("async_pulse", 32'(btn_pulse), 32'h0);
        @(negedge clk);
        set_btn(5'b10000);
        @(negedge clk);
        rst_n = 1'b1;
        sbq.push_back('{cyc + 6, 5'b10000});
        repeat (12) @(negedge clk);
        chk("right_level", 32'(btn_level), 32'h10);
        set_btn(5'b00000);
        repeat (8) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
